// File: rtl/register_scoreboard.sv
// Register write scoreboard: per-register pending-write counters that stall decode
// on read-after-write hazards or when a destination's counter is saturated.
module register_scoreboard #(
  parameter int NUM_REGS    = 16,
  parameter int SEL_WIDTH   = 4,
  parameter int COUNT_WIDTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_decoder_valid,
  input  logic                 i_decoder_re1,
  input  logic [SEL_WIDTH-1:0] i_decoder_rs1,
  input  logic                 i_decoder_re2,
  input  logic [SEL_WIDTH-1:0] i_decoder_rs2,
  input  logic                 i_decoder_we,
  input  logic [SEL_WIDTH-1:0] i_decoder_ws,
  input  logic                 i_writeback_we,
  input  logic [SEL_WIDTH-1:0] i_writeback_ws,
  input  logic                 i_flush,
  output logic                 o_stall,
  output logic [NUM_REGS-1:0]  o_busy,
  output logic                 o_error
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] rd1_hit;
  logic [NUM_REGS-1:0] rd2_hit;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] full_vec;
  logic [NUM_REGS-1:0] underflow_vec;
  logic                read_hazard;
  logic                full_hazard;
  logic                issue;
  logic                error_reg;

  // Selectors at or above NUM_REGS never match any register, so they are ignored.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [COUNT_WIDTH-1:0] count_reg;
      logic [COUNT_WIDTH-1:0] count_next;
      logic                   inc;
      logic                   dec;

      assign rd1_hit[gi]  = (i_decoder_rs1  == SEL_WIDTH'(gi));
      assign rd2_hit[gi]  = (i_decoder_rs2  == SEL_WIDTH'(gi));
      assign wr_hit[gi]   = (i_decoder_ws   == SEL_WIDTH'(gi));
      assign wb_hit[gi]   = (i_writeback_ws == SEL_WIDTH'(gi));
      assign busy[gi]     = (count_reg != '0);
      assign full_vec[gi] = (count_reg == COUNT_MAX);

      assign inc = issue && wr_hit[gi];
      assign dec = i_writeback_we && wb_hit[gi] && busy[gi];
      assign underflow_vec[gi] = i_writeback_we && wb_hit[gi] && !busy[gi];

      always_comb begin
        count_next = count_reg;
        if (inc && !dec) begin
          count_next = count_reg + COUNT_WIDTH'(1);
        end else if (dec && !inc) begin
          count_next = count_reg - COUNT_WIDTH'(1);
        end
      end

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          count_reg <= '0;
        end else if (i_flush) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_next;
        end
      end
    end
  endgenerate

  // Retire on the register being read still counts as a hazard this cycle.
  assign read_hazard = (i_decoder_re1 && |(rd1_hit & busy)) ||
                       (i_decoder_re2 && |(rd2_hit & busy));
  assign full_hazard = i_decoder_we && |(wr_hit & full_vec);
  assign o_stall     = i_decoder_valid && (read_hazard || full_hazard);
  assign issue       = i_decoder_valid && i_decoder_we && !o_stall;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      error_reg <= 1'b0;
    end else if (!i_flush && |underflow_vec) begin
      error_reg <= 1'b1;
    end
  end

  assign o_busy  = busy;
  assign o_error = error_reg;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: hazards, saturation, underflow, flush, async reset.
module tb_register_scoreboard;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_decoder_valid;
  logic        i_decoder_re1;
  logic [3:0]  i_decoder_rs1;
  logic        i_decoder_re2;
  logic [3:0]  i_decoder_rs2;
  logic        i_decoder_we;
  logic [3:0]  i_decoder_ws;
  logic        i_writeback_we;
  logic [3:0]  i_writeback_ws;
  logic        i_flush;
  logic        o_stall;
  logic [15:0] o_busy;
  logic        o_error;

  int vectors;
  int miscompares;

  register_scoreboard #(.NUM_REGS(16), .SEL_WIDTH(4), .COUNT_WIDTH(2)) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_decoder_valid (i_decoder_valid),
    .i_decoder_re1   (i_decoder_re1),
    .i_decoder_rs1   (i_decoder_rs1),
    .i_decoder_re2   (i_decoder_re2),
    .i_decoder_rs2   (i_decoder_rs2),
    .i_decoder_we    (i_decoder_we),
    .i_decoder_ws    (i_decoder_ws),
    .i_writeback_we  (i_writeback_we),
    .i_writeback_ws  (i_writeback_ws),
    .i_flush         (i_flush),
    .o_stall         (o_stall),
    .o_busy          (o_busy),
    .o_error         (o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic re1, input logic [3:0] rs1,
                       input logic we, input logic [3:0] ws,
                       input logic wbwe, input logic [3:0] wbws, input logic fl);
    i_decoder_valid = v;
    i_decoder_re1   = re1;
    i_decoder_rs1   = rs1;
    i_decoder_re2   = 1'b0;
    i_decoder_rs2   = 4'd0;
    i_decoder_we    = we;
    i_decoder_ws    = ws;
    i_writeback_we  = wbwe;
    i_writeback_ws  = wbws;
    i_flush         = fl;
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_reset_n   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with random traffic
    repeat (4) begin
      step();
      i_decoder_valid = 1'($urandom);
      i_decoder_re1   = 1'($urandom);
      i_decoder_rs1   = 4'($urandom);
      i_decoder_re2   = 1'($urandom);
      i_decoder_rs2   = 4'($urandom);
      i_decoder_we    = 1'($urandom);
      i_decoder_ws    = 4'($urandom);
      i_writeback_we  = 1'($urandom);
      i_writeback_ws  = 4'($urandom);
      i_flush         = 1'($urandom);
    end
    #1;
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_error", 32'(o_error), 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    i_reset_n = 1'b1;
    step();
    drive(1, 1, 3, 0, 0, 0, 0, 0);
    #1 check("rst_read_r3_stall", 32'(o_stall), 32'h0);
    step();

    // RAW hazard on r5
    drive(1, 0, 0, 1, 5, 0, 0, 0);
    #1 check("raw_issue_stall", 32'(o_stall), 32'h0);
    step();
    for (int c = 2; c <= 4; c++) begin
      drive(1, 1, 5, 0, 0, (c == 4), 5, 0);
      #1;
      check("raw_stall", 32'(o_stall), 32'h1);
      check("raw_busy5", 32'(o_busy[5]), 32'h1);
      step();
    end
    drive(1, 1, 5, 0, 0, 0, 0, 0);
    #1;
    check("raw_release_stall", 32'(o_stall), 32'h0);
    check("raw_release_busy5", 32'(o_busy[5]), 32'h0);
    drive(0, 1, 5, 0, 0, 0, 0, 0);
    #1 check("novalid_stall", 32'(o_stall), 32'h0);
    step();

    // Saturation on r2
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 1, 2, 0, 0, 0);
      #1 check("sat_fill_stall", 32'(o_stall), 32'h0);
      step();
    end
    drive(1, 0, 0, 1, 2, 0, 0, 0);
    #1 check("sat_full_stall", 32'(o_stall), 32'h1);
    step();
    drive(1, 0, 0, 1, 2, 1, 2, 0);
    #1 check("sat_still_full", 32'(o_stall), 32'h1);
    step();
    drive(1, 0, 0, 1, 2, 0, 0, 0);
    #1 check("sat_fourth_issues", 32'(o_stall), 32'h0);
    step();
    drive(1, 0, 0, 1, 2, 0, 0, 0);
    #1 check("sat_full_again", 32'(o_stall), 32'h1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 1, 2, 0);
      step();
      #1 check("sat_drain_busy2", 32'(o_busy[2]), (k == 2) ? 32'h0 : 32'h1);
    end

    // Simultaneous issue and retire on r7
    drive(1, 0, 0, 1, 7, 0, 0, 0);
    step();
    drive(1, 0, 0, 1, 7, 1, 7, 0);
    #1 check("same_stall", 32'(o_stall), 32'h0);
    step();
    #1 check("same_busy7", 32'(o_busy[7]), 32'h1);
    drive(0, 0, 0, 0, 0, 1, 7, 0);
    step();
    #1;
    check("same_retire_busy7", 32'(o_busy[7]), 32'h0);
    check("no_error_yet", 32'(o_error), 32'h0);

    // Underflow on r9
    drive(0, 0, 0, 0, 0, 1, 9, 0);
    #1 check("uf_before_edge", 32'(o_error), 32'h0);
    step();
    #1 check("uf_error_set", 32'(o_error), 32'h1);
    drive(1, 0, 0, 1, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    step();
    #1 check("uf_error_sticky", 32'(o_error), 32'h1);

    // Flush with r1 = 2, r4 = 1
    drive(1, 0, 0, 1, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 1, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 1, 4, 0, 0, 0);
    step();
    #1 check("fl_busy_pre", 32'(o_busy), 32'h0012);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    i_decoder_re2 = 1'b1;
    i_decoder_rs2 = 4'd4;
    #1 check("fl_re2_stall", 32'(o_stall), 32'h1);
    step();
    drive(1, 0, 0, 1, 6, 0, 0, 1);
    #1 check("fl_issue_stall", 32'(o_stall), 32'h0);
    step();
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    #1;
    check("fl_busy_post", 32'(o_busy), 32'h0);
    check("fl_read_stall", 32'(o_stall), 32'h0);
    check("fl_error_kept", 32'(o_error), 32'h1);
    step();

    // Asynchronous reset mid-cycle
    drive(1, 0, 0, 1, 3, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("ar_busy3", 32'(o_busy[3]), 32'h1);
    #2 i_reset_n = 1'b0;
    #1;
    check("ar_busy", 32'(o_busy), 32'h0);
    check("ar_error", 32'(o_error), 32'h0);
    step();
    i_reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 3, 0);
    step();
    #1 check("ar_stale_retire_error", 32'(o_error), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
